usrt_rx: RTL and testbench
==========================

Name: usrt_rx

Overview:
Synchronous serial receiver, the downstream partner of the team's USRT transmitter. Shares its clock and samples the line once per clock. Frame format: one start bit (0), 8 data bits LSB first, one stop bit (1), no oversampling. Validated bytes go into a small first-word-fall-through FIFO drained by a valid/ready consumer. Framing and overflow errors are reported to the consumer.

Parameters:
FIFO_DEPTH, 4, receive FIFO entries; power of two, minimum 2
ADDR_W, 2, log2(FIFO_DEPTH); must be consistent with FIFO_DEPTH

Ports:
i_Clock  input  1  system clock, all logic on rising edge
i_Reset_n  input  1  asynchronous, active-low reset
i_Rx_Serial  input  1  serial line, same clock domain, no synchroniser
o_Rx_Byte  output  8  FIFO head byte; valid only when o_Rx_Valid=1
o_Rx_Valid  output  1  FIFO not empty
i_Rx_Ready  input  1  consumer pop; a pop occurs when o_Rx_Valid && i_Rx_Ready at a rising edge
o_Level  output  ADDR_W+1  current FIFO occupancy, 0..FIFO_DEPTH
o_Busy  output  1  receiver FSM not in IDLE
o_Frame_Err  output  1  one-cycle pulse: stop bit sampled as 0
o_Overflow  output  1  sticky: a good byte was dropped because the FIFO was full
i_Err_Clear  input  1  synchronous clear of o_Overflow

Behaviour:
- Reset asserted, asynchronous: FSM to IDLE, armed=0, bit index=0, shift register=0, FIFO pointers and level=0.
- Reset values of outputs: o_Rx_Valid=0, o_Level=0, o_Busy=0, o_Frame_Err=0, o_Overflow=0, o_Rx_Byte=0.
- A partial frame in progress at reset is discarded.
- Armed flag:
  - Set on any sampled i_Rx_Serial=1.
  - Cleared by reset and by a framing error.
  - IDLE accepts a start bit only when armed=1 (line must be seen high first).
- FSM states IDLE, DATA, STOP. One sample per clock.
  - IDLE: if armed && i_Rx_Serial==0 -> DATA, index=0. Otherwise stay.
  - DATA: shift register[index] <= i_Rx_Serial. If index==7 -> STOP, else index+1.
  - STOP, i_Rx_Serial==1: frame good, push byte to FIFO, -> IDLE.
  - STOP, i_Rx_Serial==0: o_Frame_Err pulses the next cycle, byte discarded, armed=0, -> IDLE. That 0 is never treated as a start bit.
- Timing: if the start bit is sampled at edge S, data is sampled at S+1..S+8 and stop at S+9. The push happens at S+9, so o_Rx_Valid and o_Level update after edge S+9.
- Minimum frame spacing: a new start bit may be sampled at S+10, the first IDLE cycle. The transmitter's stop plus idle cycles always satisfy this.
- o_Busy=1 in DATA and STOP.
- FIFO behaviour:
  - First-word-fall-through: o_Rx_Byte shows the head entry combinationally from the storage array.
  - Pop and push may occur in the same edge.
  - Full and both events: pop and push both succeed, level unchanged, no overflow.
  - Empty: any pop request is ignored; a push proceeds.
  - Push while full without a pop: byte dropped, o_Overflow<=1, FIFO contents unchanged.
- Pointers wrap modulo FIFO_DEPTH. Level is tracked explicitly (not derived from pointers), width ADDR_W+1.
- o_Overflow clears on i_Err_Clear=1. If a new overflow event and i_Err_Clear coincide, set wins.
- i_Rx_Ready is ignored when o_Rx_Valid=0.

Test Plan:
- Reset release with line high, then frame 0xA5 (serial 0,1,0,1,0,0,1,0,1,1) -> o_Rx_Valid rises after edge S+9, o_Rx_Byte=0xA5, o_Level=1. Pop with ready -> o_Level=0, o_Rx_Valid=0.
- Back-to-back frames 0x00 then 0xFF, next start immediately after stop -> FIFO holds 0x00 then 0xFF in order, o_Level=2, no o_Frame_Err.
- Frame 0x3C with stop bit 0 -> one-cycle o_Frame_Err, FIFO empty. A following 0 with no intervening 1 is not accepted as a start. After a 1 then frame 0x11 -> byte 0x11 received.
- Ready held low, 5 frames 0x01..0x05 -> o_Level=4, o_Overflow=1, o_Rx_Byte=0x01. Drain yields 0x01..0x04. i_Err_Clear -> o_Overflow=0.
- FIFO full, i_Rx_Ready=1 at the same edge a frame completes -> pop and push both occur, o_Level stays 4, o_Overflow stays 0.
- Reset asserted after data bit 3 of a frame, line held low at release -> all outputs at reset values, no start accepted until the line goes high. Next full frame 0x5A is received correctly.

Source files
------------

// File: rtl/usrt_rx.sv
// Synchronous serial receiver: start/8N/stop frames sampled once per clock.
// Good bytes go into a first-word-fall-through FIFO drained by valid/ready.
module usrt_rx #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 2
) (
  input  logic              i_Clock,
  input  logic              i_Reset_n,
  input  logic              i_Rx_Serial,
  output logic [7:0]        o_Rx_Byte,
  output logic              o_Rx_Valid,
  input  logic              i_Rx_Ready,
  output logic [ADDR_W:0]   o_Level,
  output logic              o_Busy,
  output logic              o_Frame_Err,
  output logic              o_Overflow,
  input  logic              i_Err_Clear
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    STOP
  } state_t;

  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(FIFO_DEPTH);

  state_t            state;
  state_t            state_next;
  logic              armed;
  logic [2:0]        bit_idx;
  logic [7:0]        shift_reg;
  logic              start_seen;
  logic              frame_good;
  logic              frame_bad;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   level;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;
  logic              overflow_event;

  // Receiver FSM
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) state <= IDLE;
    else            state <= state_next;
  end

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    start_seen = 1'b0;
    frame_good = 1'b0;
    frame_bad  = 1'b0;
    case (state)
      IDLE: begin
        if (armed && !i_Rx_Serial) begin
          state_next = DATA;
          start_seen = 1'b1;
        end
      end
      DATA: begin
        if (bit_idx == 3'd7) state_next = STOP;
      end
      STOP: begin
        state_next = IDLE;
        if (i_Rx_Serial) frame_good = 1'b1;
        else             frame_bad  = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      armed       <= 1'b0;
      bit_idx     <= 3'd0;
      shift_reg   <= 8'h00;
      o_Frame_Err <= 1'b0;
    end else begin
      o_Frame_Err <= frame_bad;
      // A bad stop bit disarms, so its 0 can never double as a start bit.
      if (i_Rx_Serial)    armed <= 1'b1;
      else if (frame_bad) armed <= 1'b0;
      if (start_seen) begin
        bit_idx <= 3'd0;
      end else if (state == DATA) begin
        shift_reg[bit_idx] <= i_Rx_Serial;
        bit_idx            <= bit_idx + 3'd1;
      end
    end
  end

  // Receive FIFO; a pop frees the slot a same-edge push needs when full.
  assign empty          = (level == '0);
  assign full           = (level == FULL_LEVEL);
  assign pop            = !empty && i_Rx_Ready;
  assign push           = frame_good && (!full || pop);
  assign overflow_event = frame_good && full && !pop;

  // NOTE: storage has no reset; the head byte is gated by empty instead.
  always_ff @(posedge i_Clock) begin
    if (push) mem[wr_ptr] <= shift_reg;
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      o_Overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (overflow_event)   o_Overflow <= 1'b1;
      else if (i_Err_Clear) o_Overflow <= 1'b0;
    end
  end

  assign o_Rx_Byte  = empty ? 8'h00 : mem[rd_ptr];
  assign o_Rx_Valid = !empty;
  assign o_Level    = level;
  assign o_Busy     = (state != IDLE);

endmodule

// File: tb/tb_usrt_rx.sv
// Self-checking bench for usrt_rx: scripted and random frames checked
// against a queue-based FIFO model driven by the frame scripts themselves.
module tb_usrt_rx;

  localparam int DEPTH = 4;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       rx_serial = 1'b1;
  logic       rx_ready  = 1'b0;
  logic       err_clear = 1'b0;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [2:0] level;
  logic       busy;
  logic       frame_err;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [7:0] q[$];
  logic       m_ovf   = 1'b0;
  int         m_ferr  = 0;
  int         m_busy  = 0;
  int         ferr_seen = 0;
  int         busy_seen = 0;

  always #5 clk = ~clk;

  usrt_rx #(.FIFO_DEPTH(DEPTH), .ADDR_W(2)) dut (
    .i_Clock     (clk),
    .i_Reset_n   (rst_n),
    .i_Rx_Serial (rx_serial),
    .o_Rx_Byte   (rx_byte),
    .o_Rx_Valid  (rx_valid),
    .i_Rx_Ready  (rx_ready),
    .o_Level     (level),
    .o_Busy      (busy),
    .o_Frame_Err (frame_err),
    .o_Overflow  (overflow),
    .i_Err_Clear (err_clear)
  );

  always @(negedge clk) begin
    if (!rst_n)    busy_seen = 0;
    else if (busy) busy_seen = busy_seen + 1;
    if (frame_err) ferr_seen = ferr_seen + 1;
  end

  // One clock: drive inputs, advance the model, land 1 time unit after the edge.
  task automatic step(input logic ser, input logic rdy, input logic clr,
                      input logic stop_edge, input logic [7:0] b);
    logic full_b, pop_m, ovf_evt;
    rx_serial = ser;
    rx_ready  = rdy;
    err_clear = clr;
    full_b  = (q.size() == DEPTH);
    pop_m   = rdy && (q.size() != 0);
    ovf_evt = 1'b0;
    if (pop_m) void'(q.pop_front());
    if (stop_edge) begin
      if (ser) begin
        if (!full_b || pop_m) q.push_back(b);
        else                  ovf_evt = 1'b1;
      end else begin
        m_ferr++;
      end
    end
    if (ovf_evt)  m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    @(posedge clk);
    #1;
  endtask

  function automatic logic pick_ready(input int mode, input int k);
    return (mode == 1) || (mode == 2 && $urandom_range(0, 1) == 1) || (mode == 3 && k == 9);
  endfunction

  // mode: 0 ready low, 1 ready high, 2 random ready, 3 ready only on the stop edge
  task automatic send_frame(input logic [7:0] b, input logic stop, input int mode);
    step(1'b0, pick_ready(mode, 0), 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) step(b[i], pick_ready(mode, i + 1), 1'b0, 1'b0, 8'h00);
    step(stop, pick_ready(mode, 9), 1'b0, 1'b1, b);
    m_busy += 9;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rx_valid !== 1'b0)  begin errors++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
    checks++; if (level !== 3'd0)     begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (rx_byte !== 8'h00)  begin errors++; $display("FAIL reset_byte got=%h exp=00", rx_byte); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [7:0] b;
    b = 8'hA5;
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) step(b[i], 1'b0, 1'b0, 1'b0, 8'h00);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_early got=%b exp=0", rx_valid); end
    checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL basic_busy_stop got=%b exp=1", busy); end
    step(1'b1, 1'b0, 1'b0, 1'b1, b);
    m_busy += 9;
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", rx_valid); end
    checks++; if (rx_byte !== 8'hA5) begin errors++; $display("FAIL basic_byte got=%h exp=a5", rx_byte); end
    checks++; if (level !== 3'd1)    begin errors++; $display("FAIL basic_level got=%0d exp=1", level); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL basic_busy_idle got=%b exp=0", busy); end
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    checks++; if (level !== 3'(q.size())) begin errors++; $display("FAIL basic_pop_level got=%0d exp=%0d", level, q.size()); end
    checks++; if (rx_valid !== 1'b0)      begin errors++; $display("FAIL basic_pop_valid got=%b exp=0", rx_valid); end
  endtask

  task automatic test_back_to_back();
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    checks++; if (level !== 3'd2)    begin errors++; $display("FAIL b2b_level got=%0d exp=2", level); end
    checks++; if (rx_byte !== 8'h00) begin errors++; $display("FAIL b2b_first got=%h exp=00", rx_byte); end
    checks++; if (ferr_seen !== m_ferr) begin errors++; $display("FAIL b2b_frame_err got=%0d exp=%0d", ferr_seen, m_ferr); end
    checks++; if (busy_seen !== m_busy) begin errors++; $display("FAIL b2b_busy_cycles got=%0d exp=%0d", busy_seen, m_busy); end
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    checks++; if (rx_byte !== 8'hFF) begin errors++; $display("FAIL b2b_second got=%h exp=ff", rx_byte); end
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got=%b exp=0", rx_valid); end
  endtask

  task automatic test_frame_err();
    send_frame(8'h3C, 1'b0, 0);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_pulse got=%b exp=1", frame_err); end
    checks++; if (rx_valid !== 1'b0)  begin errors++; $display("FAIL ferr_discard got=%b exp=0", rx_valid); end
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_one_cycle got=%b exp=0", frame_err); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL ferr_no_start got=%b exp=0", busy); end
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL ferr_no_start2 got=%b exp=0", busy); end
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    send_frame(8'h11, 1'b1, 0);
    checks++; if (rx_byte !== 8'h11 || level !== 3'd1) begin
      errors++; $display("FAIL ferr_recover got=%h/%0d exp=11/1", rx_byte, level);
    end
    checks++; if (ferr_seen !== m_ferr) begin errors++; $display("FAIL ferr_count got=%0d exp=%0d", ferr_seen, m_ferr); end
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_overflow();
    for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b1, 0);
    checks++; if (level !== 3'd4)    begin errors++; $display("FAIL ovf_level got=%0d exp=4", level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    checks++; if (rx_byte !== 8'h01) begin errors++; $display("FAIL ovf_head got=%h exp=01", rx_byte); end
    for (int k = 1; k <= 4; k++) begin
      checks++; if (rx_byte !== 8'(k)) begin errors++; $display("FAIL ovf_drain got=%h exp=%h", rx_byte, 8'(k)); end
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    end
    checks++; if (rx_valid !== 1'b0 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_drained got=%b/%b exp=0/1", rx_valid, overflow);
    end
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL ovf_clear got=%b exp=%b", overflow, m_ovf); end
  endtask

  task automatic test_full_simultaneous();
    for (int k = 0; k < 4; k++) send_frame(8'h21 + 8'(k), 1'b1, 0);
    send_frame(8'h25, 1'b1, 3);
    checks++; if (level !== 3'd4)    begin errors++; $display("FAIL simul_level got=%0d exp=4", level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL simul_overflow got=%b exp=0", overflow); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (rx_byte !== 8'h22 + 8'(k)) begin
        errors++; $display("FAIL simul_drain got=%h exp=%h", rx_byte, 8'h22 + 8'(k));
      end
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic       stop;
    int         gap;
    for (int n = 0; n < 40; n++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 9) != 0);
      send_frame(b, stop, 2);
      gap = $urandom_range(stop ? 0 : 1, 3);
      for (int g = 0; g < gap; g++) begin
        step(1'b1, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), 1'b0, 8'h00);
      end
      checks++; if (level !== 3'(q.size())) begin errors++; $display("FAIL rand_level got=%0d exp=%0d", level, q.size()); end
      checks++; if (overflow !== m_ovf)     begin errors++; $display("FAIL rand_overflow got=%b exp=%b", overflow, m_ovf); end
      if (q.size() != 0) begin
        checks++; if (rx_byte !== q[0]) begin errors++; $display("FAIL rand_head got=%h exp=%h", rx_byte, q[0]); end
      end
    end
    checks++; if (busy_seen !== m_busy) begin errors++; $display("FAIL rand_busy_cycles got=%0d exp=%0d", busy_seen, m_busy); end
    checks++; if (ferr_seen !== m_ferr) begin errors++; $display("FAIL rand_frame_err got=%0d exp=%0d", ferr_seen, m_ferr); end
    while (q.size() != 0) step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic test_mid_frame_reset();
    logic [7:0] b;
    b = 8'h77;
    for (int k = 0; k < 5; k++) send_frame(8'h40 + 8'(k), 1'b1, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) step(b[i], 1'b0, 1'b0, 1'b0, 8'h00);
    rx_serial = 1'b0;
    rst_n     = 1'b0;
    q.delete();
    m_ovf  = 1'b0;
    m_busy = 0;
    #2;
    checks++; if (busy !== 1'b0 || rx_valid !== 1'b0 || level !== 3'd0) begin
      errors++; $display("FAIL mreset_state got=%b/%b/%0d exp=0/0/0", busy, rx_valid, level);
    end
    checks++; if (overflow !== 1'b0 || frame_err !== 1'b0 || rx_byte !== 8'h00) begin
      errors++; $display("FAIL mreset_flags got=%b/%b/%h exp=0/0/00", overflow, frame_err, rx_byte);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++; if (busy !== 1'b0 || busy_seen !== 0) begin
      errors++; $display("FAIL mreset_no_start got=%b/%0d exp=0/0", busy, busy_seen);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    send_frame(8'h5A, 1'b1, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++; if (rx_byte !== 8'h5A || level !== 3'd1) begin
      errors++; $display("FAIL mreset_frame got=%h/%0d exp=5a/1", rx_byte, level);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_frame_err();
    test_overflow();
    test_full_simultaneous();
    test_random();
    test_mid_frame_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
